// File: rtl/lsu_pkg.sv
// Shared types and default widths for the load/store unit and its nibble merge helper.
// Latency: none (declarations only).
// Backpressure: none (declarations only).
package lsu_pkg;

    localparam int LSU_DATA_W = 8;
    localparam int LSU_NIB_W  = 4;
    localparam int LSU_ADDR_W = 1;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        RD   = 2'd1,
        CAP  = 2'd2,
        WR   = 2'd3
    } state_t;

    // Request fields captured at the accept edge; widths follow the package defaults.
    typedef struct packed {
        logic                  we;
        logic                  full;
        logic                  half;
        logic [LSU_ADDR_W-1:0] addr;
        logic [LSU_DATA_W-1:0] wdata;
    } req_t;

endpackage

// File: rtl/load_store_unit_nibble_merge.sv
// Nibble insert for read-modify-write stores and nibble extract for loads.
// Latency: combinational.
// Backpressure: none.
module nibble_merge
    import lsu_pkg::*;
#(
    parameter int DATA_W = LSU_DATA_W,
    parameter int NIB_W  = LSU_NIB_W
) (
    input  logic [DATA_W-1:0] old_word,
    input  logic [NIB_W-1:0]  nib,
    input  logic              half,
    input  logic              full,
    output logic [DATA_W-1:0] merged,
    output logic [DATA_W-1:0] load_val
);

    // Byte accesses pass the old word through untouched; nibble accesses
    // replace (store) or isolate and zero-extend (load) the selected half.
    always_comb begin
        merged   = old_word;
        load_val = old_word;
        if (!full) begin
            if (half) begin
                merged[DATA_W-1:NIB_W] = nib;
                load_val = {{(DATA_W-NIB_W){1'b0}}, old_word[DATA_W-1:NIB_W]};
            end else begin
                merged[NIB_W-1:0] = nib;
                load_val = {{(DATA_W-NIB_W){1'b0}}, old_word[NIB_W-1:0]};
            end
        end
    end

endmodule

// File: rtl/load_store_unit.sv
// Sequences load/store requests onto a data_ram with a registered read address, merging nibble stores by read-modify-write.
// Latency from accept edge to rsp_valid: byte store 2, load 3, nibble store 4 (forwarded load / nibble store 2 with LSU_LAST_WR_FWD_EN).
// Backpressure: req_ready is high only in IDLE, one request in flight; rsp_valid is a one-cycle pulse with no response-side stall.
module load_store_unit
    import lsu_pkg::*;
#(
    parameter int DATA_W = LSU_DATA_W,
    parameter int NIB_W  = LSU_NIB_W,
    parameter int ADDR_W = LSU_ADDR_W
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic              req_valid,
    output logic              req_ready,
    input  logic              req_we,
    input  logic              req_full,
    input  logic              req_half,
    input  logic [ADDR_W-1:0] req_addr,
    input  logic [DATA_W-1:0] req_wdata,
    output logic              rsp_valid,
    output logic [DATA_W-1:0] rsp_rdata,
    output logic [DATA_W-1:0] ram_data,
    output logic [ADDR_W-1:0] ram_addr,
    output logic              ram_we,
    input  logic [DATA_W-1:0] ram_q
);

    state_t state;
    req_t   lat;

    logic [DATA_W-1:0] m_old;
    logic [NIB_W-1:0]  m_nib;
    logic              m_half;
    logic              m_full;
    logic [DATA_W-1:0] merged;
    logic [DATA_W-1:0] load_val;

    // ram_we decodes straight from state so an async reset drops it at once.
    assign req_ready = (state == IDLE);
    assign ram_we    = (state == WR);
    assign ram_addr  = lat.addr;

`ifdef LSU_LAST_WR_FWD_EN
    logic              last_valid;
    logic [ADDR_W-1:0] last_addr;
    logic [DATA_W-1:0] last_data;
    logic              fwd_q;
    logic              hit;

    assign hit = last_valid && (last_addr == req_addr);

    // In IDLE the merge works on the incoming request against the shadow word
    // (forwarded nibble store); otherwise on the latched request against the
    // RAM read, or against the shadow word for a forwarded load.
    always_comb begin
        m_old  = ram_q;
        m_nib  = lat.wdata[NIB_W-1:0];
        m_half = lat.half;
        m_full = lat.full;
        if (state == IDLE) begin
            m_old  = last_data;
            m_nib  = req_wdata[NIB_W-1:0];
            m_half = req_half;
            m_full = req_full;
        end else if (fwd_q) begin
            m_old  = last_data;
        end
    end
`else
    // The merge always sees the latched request and the word read from RAM.
    always_comb begin
        m_old  = ram_q;
        m_nib  = lat.wdata[NIB_W-1:0];
        m_half = lat.half;
        m_full = lat.full;
    end
`endif

    nibble_merge #(
        .DATA_W (DATA_W),
        .NIB_W  (NIB_W)
    ) u_merge (
        .old_word (m_old),
        .nib      (m_nib),
        .half     (m_half),
        .full     (m_full),
        .merged   (merged),
        .load_val (load_val)
    );

    // Request FSM: ram_data doubles as the holding register for the merged word.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state     <= IDLE;
            lat       <= '0;
            rsp_valid <= 1'b0;
            rsp_rdata <= '0;
            ram_data  <= '0;
`ifdef LSU_LAST_WR_FWD_EN
            fwd_q      <= 1'b0;
            last_valid <= 1'b0;
            last_addr  <= '0;
            last_data  <= '0;
`endif
        end else begin
            rsp_valid <= 1'b0;
            case (state)
                IDLE: begin
                    if (req_valid) begin
                        lat.we    <= req_we;
                        lat.full  <= req_full;
                        lat.half  <= req_half;
                        lat.addr  <= req_addr;
                        lat.wdata <= req_wdata;
                        if (req_we && req_full) begin
                            ram_data <= req_wdata;
                            state    <= WR;
                        end else begin
`ifdef LSU_LAST_WR_FWD_EN
                            fwd_q <= hit;
                            if (hit && req_we) begin
                                ram_data <= merged;
                                state    <= WR;
                            end else if (hit) begin
                                state    <= CAP;
                            end else begin
                                state    <= RD;
                            end
`else
                            state <= RD;
`endif
                        end
                    end
                end
                RD: begin
                    state <= CAP;
                end
                CAP: begin
                    if (lat.we) begin
                        ram_data <= merged;
                        state    <= WR;
                    end else begin
                        rsp_rdata <= load_val;
                        rsp_valid <= 1'b1;
                        state     <= IDLE;
                    end
                end
                WR: begin
                    rsp_valid <= 1'b1;
                    state     <= IDLE;
`ifdef LSU_LAST_WR_FWD_EN
                    last_valid <= 1'b1;
                    last_addr  <= lat.addr;
                    last_data  <= ram_data;
`endif
                end
                default: begin
                    state <= IDLE;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_load_store_unit.sv
// Directed bench for load_store_unit with a behavioural registered-address data_ram model.
// Latency: cycle N means rsp_valid was driven high by the Nth clock edge, counting the accepting edge as the first.
// Backpressure: requests are issued only while the unit is idle; back-to-back holds req_valid high.
module tb_load_store_unit;

    logic       clk = 1'b0;
    logic       rst_n;
    logic       req_valid;
    logic       req_ready;
    logic       req_we;
    logic       req_full;
    logic       req_half;
    logic [0:0] req_addr;
    logic [7:0] req_wdata;
    logic       rsp_valid;
    logic [7:0] rsp_rdata;
    logic [7:0] ram_data;
    logic [0:0] ram_addr;
    logic       ram_we;
    logic [7:0] ram_q;

    int checks   = 0;
    int failures = 0;

`ifdef LSU_LAST_WR_FWD_EN
    localparam int LAT_LOAD_REPEAT = 2;
    localparam int LAT_NST_REPEAT  = 2;
    localparam int BUSY_NST_TO_WR  = 1;
`else
    localparam int LAT_LOAD_REPEAT = 3;
    localparam int LAT_NST_REPEAT  = 4;
    localparam int BUSY_NST_TO_WR  = 3;
`endif

    always #5 clk = ~clk;

    load_store_unit dut (
        .clk       (clk),
        .rst_n     (rst_n),
        .req_valid (req_valid),
        .req_ready (req_ready),
        .req_we    (req_we),
        .req_full  (req_full),
        .req_half  (req_half),
        .req_addr  (req_addr),
        .req_wdata (req_wdata),
        .rsp_valid (rsp_valid),
        .rsp_rdata (rsp_rdata),
        .ram_data  (ram_data),
        .ram_addr  (ram_addr),
        .ram_we    (ram_we),
        .ram_q     (ram_q)
    );

    // data_ram model: write on we, read through a registered address.
    logic [7:0] mem [0:1];
    logic [0:0] addr_q;
    logic       mem_clr;

    always @(posedge clk) begin
        if (mem_clr) begin
            mem[0] <= 8'h00;
            mem[1] <= 8'h00;
        end else if (ram_we) begin
            mem[ram_addr] <= ram_data;
        end
        addr_q <= ram_addr;
    end
    assign ram_q = mem[addr_q];

    initial begin
        #200000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    // Issue one request from idle and observe it until rsp_valid (bounded).
    task automatic issue(input logic we, input logic full, input logic half,
                         input logic [0:0] addr, input logic [7:0] wdata,
                         output int lat, output int wr_cnt, output logic [7:0] wr_data,
                         output logic [0:0] wr_addr, output logic [7:0] rdata);
        lat = 0; wr_cnt = 0; wr_data = 8'h00; wr_addr = 1'b0; rdata = 8'h00;
        @(negedge clk);
        req_we = we; req_full = full; req_half = half; req_addr = addr; req_wdata = wdata;
        req_valid = 1'b1;
        @(posedge clk);
        @(negedge clk);
        req_valid = 1'b0;
        for (int n = 1; n <= 20; n++) begin
            if (n > 1) @(negedge clk);
            if (ram_we) begin
                wr_cnt++;
                wr_data = ram_data;
                wr_addr = ram_addr;
            end
            if (rsp_valid) begin
                lat   = n;
                rdata = rsp_rdata;
                break;
            end
        end
    endtask

    task automatic test_reset();
        rst_n = 1'b0; req_valid = 1'b0; req_we = 1'b0; req_full = 1'b0;
        req_half = 1'b0; req_addr = 1'b0; req_wdata = 8'h00; mem_clr = 1'b1;
        repeat (3) @(posedge clk);
        @(negedge clk);
        checks++; if (req_ready !== 1'b1) begin failures++; $display("FAIL reset_ready: got %b want 1", req_ready); end
        checks++; if (rsp_valid !== 1'b0) begin failures++; $display("FAIL reset_rsp_valid: got %b want 0", rsp_valid); end
        checks++; if (ram_we !== 1'b0) begin failures++; $display("FAIL reset_ram_we: got %b want 0", ram_we); end
        checks++; if (ram_addr !== 1'b0) begin failures++; $display("FAIL reset_ram_addr: got %h want 0", ram_addr); end
        checks++; if (ram_data !== 8'h00) begin failures++; $display("FAIL reset_ram_data: got %h want 00", ram_data); end
        checks++; if (rsp_rdata !== 8'h00) begin failures++; $display("FAIL reset_rsp_rdata: got %h want 00", rsp_rdata); end
        rst_n = 1'b1;
        mem_clr = 1'b0;
    endtask

    task automatic test_byte_store();
        int lat, wr_cnt; logic [7:0] wd, rd; logic [0:0] wa;
        issue(1'b1, 1'b1, 1'b0, 1'b0, 8'hA5, lat, wr_cnt, wd, wa, rd);
        checks++; if (lat !== 2) begin failures++; $display("FAIL bst_latency: got %0d want 2", lat); end
        checks++; if (wr_cnt !== 1) begin failures++; $display("FAIL bst_we_cycles: got %0d want 1", wr_cnt); end
        checks++; if (wd !== 8'hA5) begin failures++; $display("FAIL bst_ram_data: got %h want a5", wd); end
        checks++; if (wa !== 1'b0) begin failures++; $display("FAIL bst_ram_addr: got %h want 0", wa); end
        checks++; if (mem[0] !== 8'hA5) begin failures++; $display("FAIL bst_mem0: got %h want a5", mem[0]); end
        checks++; if (rd !== 8'h00) begin failures++; $display("FAIL bst_rdata_hold: got %h want 00", rd); end
    endtask

    task automatic test_byte_load();
        int lat, wr_cnt; logic [7:0] wd, rd; logic [0:0] wa;
        issue(1'b0, 1'b1, 1'b0, 1'b0, 8'h00, lat, wr_cnt, wd, wa, rd);
        checks++; if (lat !== LAT_LOAD_REPEAT) begin failures++; $display("FAIL bld_latency: got %0d want %0d", lat, LAT_LOAD_REPEAT); end
        checks++; if (wr_cnt !== 0) begin failures++; $display("FAIL bld_no_write: got %0d want 0", wr_cnt); end
        checks++; if (rd !== 8'hA5) begin failures++; $display("FAIL bld_rdata: got %h want a5", rd); end
    endtask

    task automatic test_nibble();
        int lat, wr_cnt; logic [7:0] wd, rd; logic [0:0] wa;
        // High nibble of 0xA5 replaced by 3 -> 0x35.
        issue(1'b1, 1'b0, 1'b1, 1'b0, 8'h03, lat, wr_cnt, wd, wa, rd);
        checks++; if (lat !== LAT_NST_REPEAT) begin failures++; $display("FAIL nst_latency: got %0d want %0d", lat, LAT_NST_REPEAT); end
        checks++; if (wd !== 8'h35) begin failures++; $display("FAIL nst_ram_data: got %h want 35", wd); end
        checks++; if (mem[0] !== 8'h35) begin failures++; $display("FAIL nst_mem0: got %h want 35", mem[0]); end
        checks++; if (rd !== 8'hA5) begin failures++; $display("FAIL nst_rdata_hold: got %h want a5", rd); end
        issue(1'b0, 1'b0, 1'b0, 1'b0, 8'h00, lat, wr_cnt, wd, wa, rd);
        checks++; if (rd !== 8'h05) begin failures++; $display("FAIL nld_lo: got %h want 05", rd); end
        checks++; if (lat !== LAT_LOAD_REPEAT) begin failures++; $display("FAIL nld_latency: got %0d want %0d", lat, LAT_LOAD_REPEAT); end
        issue(1'b0, 1'b0, 1'b1, 1'b0, 8'h00, lat, wr_cnt, wd, wa, rd);
        checks++; if (rd !== 8'h03) begin failures++; $display("FAIL nld_hi: got %h want 03", rd); end
    endtask

    task automatic test_back_to_back();
        int  busy;
        int  lat;
        logic seen;
        busy = 0; lat = 0; seen = 1'b0;
        @(negedge clk);
        req_we = 1'b1; req_full = 1'b1; req_half = 1'b0; req_addr = 1'b0; req_wdata = 8'h11;
        req_valid = 1'b1;
        @(posedge clk);
        for (int n = 1; n <= 20; n++) begin
            @(negedge clk);
            if (rsp_valid) begin
                seen = 1'b1;
                break;
            end
            if (req_ready === 1'b0) busy++;
        end
        checks++; if (seen !== 1'b1) begin failures++; $display("FAIL b2b_first_rsp: got %b want 1", seen); end
        checks++; if (busy !== 1) begin failures++; $display("FAIL b2b_busy_cycles: got %0d want 1", busy); end
        checks++; if (req_ready !== 1'b1) begin failures++; $display("FAIL b2b_ready_in_rsp: got %b want 1", req_ready); end
        req_addr = 1'b1; req_wdata = 8'h22;
        @(posedge clk);
        @(negedge clk);
        req_valid = 1'b0;
        for (int n = 1; n <= 20; n++) begin
            if (n > 1) @(negedge clk);
            if (rsp_valid) begin
                lat = n;
                break;
            end
        end
        checks++; if (lat !== 2) begin failures++; $display("FAIL b2b_second_latency: got %0d want 2", lat); end
        checks++; if (mem[0] !== 8'h11) begin failures++; $display("FAIL b2b_mem0: got %h want 11", mem[0]); end
        checks++; if (mem[1] !== 8'h22) begin failures++; $display("FAIL b2b_mem1: got %h want 22", mem[1]); end
    endtask

    task automatic test_reset_in_write();
        int   busy;
        logic in_wr;
        busy = 0; in_wr = 1'b0;
        @(negedge clk);
        req_we = 1'b1; req_full = 1'b0; req_half = 1'b0; req_addr = 1'b1; req_wdata = 8'h07;
        req_valid = 1'b1;
        @(posedge clk);
        for (int n = 1; n <= 20; n++) begin
            @(negedge clk);
            req_valid = 1'b0;
            if (req_ready === 1'b0) busy++;
            if (ram_we) begin
                in_wr = 1'b1;
                break;
            end
        end
        checks++; if (in_wr !== 1'b1) begin failures++; $display("FAIL rst_wr_reached: got %b want 1", in_wr); end
        checks++; if (busy !== BUSY_NST_TO_WR) begin failures++; $display("FAIL rst_busy_cycles: got %0d want %0d", busy, BUSY_NST_TO_WR); end
        rst_n = 1'b0;
        #1;
        checks++; if (ram_we !== 1'b0) begin failures++; $display("FAIL rst_wr_we_drop: got %b want 0", ram_we); end
        checks++; if (req_ready !== 1'b1) begin failures++; $display("FAIL rst_wr_idle: got %b want 1", req_ready); end
        checks++; if (rsp_valid !== 1'b0) begin failures++; $display("FAIL rst_wr_rsp: got %b want 0", rsp_valid); end
        @(posedge clk);
        @(negedge clk);
        rst_n = 1'b1;
        @(negedge clk);
        checks++; if (mem[1] !== 8'h22) begin failures++; $display("FAIL rst_wr_mem1: got %h want 22", mem[1]); end
        checks++; if (rsp_valid !== 1'b0) begin failures++; $display("FAIL rst_wr_no_rsp: got %b want 0", rsp_valid); end
    endtask

    task automatic test_forward();
        int lat, wr_cnt; logic [7:0] wd, rd; logic [0:0] wa;
        issue(1'b1, 1'b1, 1'b0, 1'b1, 8'h5C, lat, wr_cnt, wd, wa, rd);
        checks++; if (mem[1] !== 8'h5C) begin failures++; $display("FAIL fwd_byte_mem1: got %h want 5c", mem[1]); end
        issue(1'b1, 1'b0, 1'b0, 1'b1, 8'h0F, lat, wr_cnt, wd, wa, rd);
        checks++; if (lat !== LAT_NST_REPEAT) begin failures++; $display("FAIL fwd_nst_latency: got %0d want %0d", lat, LAT_NST_REPEAT); end
        checks++; if (wd !== 8'h5F) begin failures++; $display("FAIL fwd_nst_ram_data: got %h want 5f", wd); end
        checks++; if (wa !== 1'b1) begin failures++; $display("FAIL fwd_nst_ram_addr: got %h want 1", wa); end
        checks++; if (mem[1] !== 8'h5F) begin failures++; $display("FAIL fwd_nst_mem1: got %h want 5f", mem[1]); end
    endtask

    initial begin
        test_reset();
        test_byte_store();
        test_byte_load();
        test_nibble();
        test_back_to_back();
        test_reset_in_write();
        test_forward();
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule

// File: doc/load_store_unit.md
Name: load_store_unit

Overview:
Upstream sequencer for data_ram in the 4-bit processor v2 datapath. It accepts load/store requests from the control unit over a valid/ready handshake and drives data_ram's data, address and write-enable.
- Handles data_ram's one-cycle registered-address read latency.
- Performs read-modify-write so the 4-bit core can store single nibbles into 8-bit RAM words.
- Returns load data and store completion on a one-cycle response pulse.

Parameters:
- DATA_W, 8, RAM word width.
- NIB_W, 4, nibble width (DATA_W/2).
- ADDR_W, 1, RAM address width.

Ports:
- clk  in  1  clock, rising edge.
- rst_n  in  1  asynchronous active-low reset.
- req_valid  in  1  request present.
- req_ready  out  1  unit can accept a request.
- req_we  in  1  1=store, 0=load.
- req_full  in  1  1=byte access, 0=nibble access.
- req_half  in  1  nibble select: 0=[3:0], 1=[7:4]. Ignored when req_full=1.
- req_addr  in  ADDR_W  word address.
- req_wdata  in  DATA_W  store data; nibble stores use [NIB_W-1:0].
- rsp_valid  out  1  one-cycle completion pulse.
- rsp_rdata  out  DATA_W  load result.
- ram_data  out  DATA_W  to data_ram data.
- ram_addr  out  ADDR_W  to data_ram addr_d.
- ram_we  out  1  to data_ram we_d.
- ram_q  in  DATA_W  from data_ram out_dram.

Behaviour:
- Reset (async, rst_n=0):
  - state=IDLE; latched request fields, rsp_valid, rsp_rdata, ram_data and ram_addr all 0.
  - ram_we drops immediately, because it decodes from state.
  - An in-flight write is aborted. RAM contents are unchanged unless a clk edge occurs with ram_we=1.
- Handshake:
  - req_ready=1 only in IDLE.
  - A request is accepted on a clk edge with req_valid&req_ready; all request fields are latched at that edge.
  - req_* fields are ignored while req_ready=0.
- FSM states: IDLE, RD, CAP, WR.
  - IDLE: accept → byte store goes to WR; load or nibble store goes to RD.
  - RD: ram_addr=latched addr, ram_we=0 (data_ram registers the address). Always → CAP.
  - CAP: ram_q holds the old word. Load → register rsp_rdata and go to IDLE. Nibble store → merge into a holding register and go to WR.
  - WR: ram_we=1, ram_data = byte or merged word. Always → IDLE.
- ram_addr always equals the latched address. ram_we=1 only in WR.
- Nibble merge: req_half=0 gives {old[7:4], wdata[3:0]}; req_half=1 gives {wdata[3:0], old[3:0]}.
- Load result:
  - Byte load returns ram_q.
  - Nibble load returns the selected nibble zero-extended to DATA_W.
- rsp_valid: registered, high for exactly one cycle after leaving CAP (load) or WR (store). For stores, rsp_rdata holds its previous value.
- Latency, accept edge to rsp_valid high:
  - byte store: 2 cycles.
  - load: 3 cycles.
  - nibble store: 4 cycles.
- Back-to-back: rsp_valid overlaps IDLE, so a new request may be accepted in the same cycle rsp_valid is high.
- Load after store to the same address reads the new data, since the write completes before IDLE.

Optional Feature:
- Macro: LSU_LAST_WR_FWD_EN.
- When defined:
  - A shadow register holds {last_valid, last_addr, last_data}, updated at every WR edge and cleared on reset.
  - A request whose addr matches last_addr with last_valid=1 skips RD/CAP and uses last_data as the old word.
  - Forwarded nibble store: IDLE→WR, 2 cycles.
  - Forwarded load: IDLE→CAP-equivalent response, 2 cycles, no RAM read.
- When undefined: no shadow register; the latencies above apply unconditionally.

Decomposition:
- Package lsu_pkg contains:
  - state enum (IDLE, RD, CAP, WR);
  - DATA_W, NIB_W and ADDR_W default constants;
  - the request struct {we, full, half, addr, wdata}.
- One sub-module, nibble_merge: combinational, inputs old word, nibble, half, full; outputs the merged word and the extracted load value.

Test Plan:
- Reset, then byte store addr=0 wdata=0xA5 → ram_we high exactly one cycle in WR with ram_data=0xA5; rsp_valid 2 cycles after accept.
- Byte load addr=0 after the previous test → rsp_rdata=0xA5, rsp_valid 3 cycles after accept.
- Word 0=0xA5, nibble store half=1 wdata=0x3 → RAM word 0=0x35. A following nibble load half=0 returns 0x05.
- Back-to-back stores to addr=0 then addr=1 with req_valid held high → second accepted in the rsp_valid cycle; both words correct; req_ready low in RD/CAP/WR.
- Assert rst_n=0 during WR of a nibble store → ram_we falls immediately, state=IDLE, rsp_valid=0, RAM word unchanged.
- With LSU_LAST_WR_FWD_EN: byte store addr=1 wdata=0x5C, then nibble store addr=1 half=0 wdata=0xF → no RD cycle, RAM word 1=0x5F, latency 2 cycles.
